// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg: shared types and helpers for the FIFO pointer/flag controller.
package fifo_ctrl_pkg;

    // Per-cycle operation, encoded as {write accepted, read accepted}.
    typedef enum logic [1:0] {
        OP_NOP = 2'b00,
        OP_RD  = 2'b01,
        OP_WR  = 2'b10,
        OP_RW  = 2'b11
    } fifo_op_t;

    // FIFO depth for a given register-file address width.
    function automatic int unsigned fifo_depth(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

endpackage

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer/flag controller that turns a 1W/1R (combinational read)
// register file into a first-word-fall-through circular FIFO.
// Optional build macro FIFO_CTRL_ERR_EN adds sticky o_overflow/o_underflow.
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH      = 2,
    parameter int ALMOST_FULL_LVL = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_wr,
    input  logic                  i_rd,
    output logic                  o_write_en,
    output logic [ADDR_WIDTH-1:0] o_write_addr,
    output logic [ADDR_WIDTH-1:0] o_read_addr,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_almost_full,
`ifdef FIFO_CTRL_ERR_EN
    output logic                  o_overflow,
    output logic                  o_underflow,
`endif
    output logic [ADDR_WIDTH:0]   o_count
);

    localparam int DEPTH = int'(fifo_depth(ADDR_WIDTH));
    // Out-of-range levels are clamped so the flag can still assert at full.
    localparam int AF_CLAMP = (ALMOST_FULL_LVL > DEPTH) ? DEPTH : ALMOST_FULL_LVL;
    localparam logic [ADDR_WIDTH:0] AF_LVL = (ADDR_WIDTH+1)'(AF_CLAMP);

    logic [ADDR_WIDTH-1:0] r_wptr, r_rptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_full, r_empty, r_almost_full;

    logic [ADDR_WIDTH-1:0] w_wptr_inc, w_rptr_inc;
    logic [ADDR_WIDTH-1:0] w_wptr_nxt, w_rptr_nxt;
    logic [ADDR_WIDTH:0]   w_count_nxt;
    logic                  w_full_nxt, w_empty_nxt, w_af_nxt;
    logic                  w_wr_ok, w_rd_ok;
    fifo_op_t              w_op;

    // A pop is only honoured when data is present; a push is honoured when
    // there is room, or when full but a pop frees the slot in the same cycle
    // (the read port sees the old head before the write lands at the edge).
    assign w_rd_ok    = i_rd & ~r_empty;
    assign w_wr_ok    = i_wr & (~r_full | w_rd_ok);
    assign w_op       = fifo_op_t'({w_wr_ok, w_rd_ok});
    assign w_wptr_inc = r_wptr + ADDR_WIDTH'(1);
    assign w_rptr_inc = r_rptr + ADDR_WIDTH'(1);

    // Next-state decode for pointers, occupancy and flags.
    always_comb begin
        w_wptr_nxt  = r_wptr;
        w_rptr_nxt  = r_rptr;
        w_count_nxt = r_count;
        w_full_nxt  = r_full;
        w_empty_nxt = r_empty;
        case (w_op)
            OP_RD: begin
                w_rptr_nxt  = w_rptr_inc;
                w_count_nxt = r_count - (ADDR_WIDTH+1)'(1);
                w_full_nxt  = 1'b0;
                w_empty_nxt = (w_rptr_inc == r_wptr);
            end
            OP_WR: begin
                w_wptr_nxt  = w_wptr_inc;
                w_count_nxt = r_count + (ADDR_WIDTH+1)'(1);
                w_empty_nxt = 1'b0;
                w_full_nxt  = (w_wptr_inc == r_rptr);
            end
            OP_RW: begin
                w_wptr_nxt = w_wptr_inc;
                w_rptr_nxt = w_rptr_inc;
            end
            default: ;
        endcase
        w_af_nxt = (w_count_nxt >= AF_LVL);
    end

    // State register; reset discards the logical contents immediately.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
            r_full        <= 1'b0;
            r_empty       <= 1'b1;
            r_almost_full <= 1'b0;
        end else begin
            r_wptr        <= w_wptr_nxt;
            r_rptr        <= w_rptr_nxt;
            r_count       <= w_count_nxt;
            r_full        <= w_full_nxt;
            r_empty       <= w_empty_nxt;
            r_almost_full <= w_af_nxt;
        end
    end

`ifdef FIFO_CTRL_ERR_EN
    logic r_overflow, r_underflow;

    // Sticky error flags: a dropped push (full, no pop) or a dropped pop
    // (empty, no push) sets them; only reset clears them.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (i_wr & r_full & ~i_rd)
                r_overflow <= 1'b1;
            if (i_rd & r_empty & ~i_wr)
                r_underflow <= 1'b1;
        end
    end

    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;
`endif

    // The strobe is held low while reset is asserted, whatever i_wr does.
    assign o_write_en    = w_wr_ok & i_rst_n;
    assign o_write_addr  = r_wptr;
    assign o_read_addr   = r_rptr;
    assign o_full        = r_full;
    assign o_empty       = r_empty;
    assign o_almost_full = r_almost_full;
    assign o_count       = r_count;

endmodule
